// File: rtl/key_schedule_seq.sv
// AES-128 key-expansion sequencer: walks round keys 0..10 out over valid/ready.
// Optional build macro KEY_STORE_EN adds an 11-entry round-key store with registered read port.

module calc_4k (
  input  logic [31:0] pi_closer,
  input  logic [31:0] pi_further,
  input  logic [31:0] pi_rcon_val,
  output logic [31:0] po_word
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] rot_c;
  logic [31:0] sub_c;

  assign rot_c = {pi_closer[23:0], pi_closer[31:24]};
  assign sub_c = {sbox(rot_c[31:24]), sbox(rot_c[23:16]), sbox(rot_c[15:8]), sbox(rot_c[7:0])};
  assign po_word = sub_c ^ pi_further ^ pi_rcon_val;

endmodule

module key_schedule_seq (
  input  logic         pi_clk,
  input  logic         pi_rst,
  input  logic         pi_start,
  input  logic [127:0] pi_key,
  input  logic         pi_key_ready,
  output logic [127:0] po_round_key,
  output logic [3:0]   po_round_idx,
  output logic         po_key_valid,
  output logic         po_busy,
  output logic         po_done,
  input  logic [3:0]   pi_rd_idx,
  output logic [127:0] po_rd_key
);

  localparam int unsigned LAST_IDX = 10;
  localparam int unsigned NUM_KEYS = 11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q;
  logic [127:0]   key_q;
  logic [3:0]     idx_q;
  logic           valid_q;
  logic           busy_q;
  logic           done_q;

  logic           hs_c;
  logic [3:0]     idx_d;
  logic [127:0]   key_d;
  logic [7:0]     rc_c;
  logic [31:0]    n0_c;

  assign hs_c  = valid_q & pi_key_ready;
  assign idx_d = idx_q + 4'd1;

  // Round constant for the key about to be formed
  always_comb begin
    rc_c = 8'h00;
    case (idx_d)
      4'd1:    rc_c = 8'h01;
      4'd2:    rc_c = 8'h02;
      4'd3:    rc_c = 8'h04;
      4'd4:    rc_c = 8'h08;
      4'd5:    rc_c = 8'h10;
      4'd6:    rc_c = 8'h20;
      4'd7:    rc_c = 8'h40;
      4'd8:    rc_c = 8'h80;
      4'd9:    rc_c = 8'h1b;
      4'd10:   rc_c = 8'h36;
      default: rc_c = 8'h00;
    endcase
  end

  calc_4k u_calc_4k (
    .pi_closer   (key_q[31:0]),
    .pi_further  (key_q[127:96]),
    .pi_rcon_val ({rc_c, 24'h0}),
    .po_word     (n0_c)
  );

  always_comb begin
    key_d[127:96] = n0_c;
    key_d[95:64]  = key_d[127:96] ^ key_q[95:64];
    key_d[63:32]  = key_d[95:64]  ^ key_q[63:32];
    key_d[31:0]   = key_d[63:32]  ^ key_q[31:0];
  end

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pi_start) begin
            key_q   <= pi_key;
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (hs_c) begin
            if (idx_q == 4'(LAST_IDX)) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              key_q <= key_d;
              idx_q <= idx_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign po_round_key = key_q;
  assign po_round_idx = idx_q;
  assign po_key_valid = valid_q;
  assign po_busy      = busy_q;
  assign po_done      = done_q;

`ifdef KEY_STORE_EN
  logic [127:0] store_q [NUM_KEYS];
  logic [127:0] rd_key_q;

  // Each key is written the cycle it first becomes visible on po_round_key
  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) store_q[i] <= '0;
      rd_key_q <= '0;
    end else begin
      if (state_q == IDLE && pi_start) begin
        for (int i = 1; i < int'(NUM_KEYS); i++) store_q[i] <= '0;
        store_q[0] <= pi_key;
      end else if (state_q == RUN && hs_c && idx_q != 4'(LAST_IDX)) begin
        store_q[idx_d] <= key_d;
      end
      rd_key_q <= (32'(pi_rd_idx) < NUM_KEYS) ? store_q[pi_rd_idx] : '0;
    end
  end

  assign po_rd_key = rd_key_q;
`else
  logic unused_rd_idx;

  assign unused_rd_idx = ^pi_rd_idx;
  assign po_rd_key     = '0;
`endif

endmodule
